stream_capture_buffer: RTL and testbench
========================================

Name: stream_capture_buffer

Overview:
- Sink at the far end of the 64-bit processing stream (data, data_valid).
- Captures filter output samples into an on-chip buffer of DEPTH words.
- Exposes full, empty and overflow status.
- Lets the host-side read logic drain the samples as 32-bit halves over a request/valid read port.
- Sits between any processing block (IIR, moving average) and the host bridge.

Parameters:
- DEPTH, 2048, buffer capacity in 64-bit samples (power of two).
- ADDR_W, 11, log2(DEPTH).
- SKIP, 0, valid samples discarded after arming, before storing begins.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  arm capture; low returns to IDLE with stored data kept
- clear  in  1  synchronous flush of buffer and flags
- data_valid  in  1  input sample strobe
- data  in  64  signed input sample
- sink_ready  out  1  block is currently storing or skipping samples
- rd_req  in  1  host read request, one 32-bit half per pulse
- rd_data  out  32  read data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- count  out  ADDR_W+1  stored samples
- fifo_lleno  out  1  count == DEPTH
- fifo_vacio  out  1  count == 0
- overflow  out  1  sticky, sample dropped while full

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state IDLE.
  - wr_ptr, rd_ptr, count, skip counter, half select all 0.
  - rd_data 0, rd_valid 0, overflow 0, sink_ready 0, fifo_lleno 0, fifo_vacio 1.
- Priority: reset > clear > enable low > normal operation.
- clear:
  - Forces IDLE and zeroes pointers, count, overflow and half select in one cycle.
  - An rd_req in the same cycle is ignored.
- FSM transitions (evaluated each cycle):
  - IDLE: if enable, go to SKIP (or straight to CAPTURE when SKIP == 0). Skip counter cleared on entry.
  - SKIP: each data_valid increments the skip counter. When it reaches SKIP, go to CAPTURE; the sample that completes the skip is not stored.
  - CAPTURE: each data_valid writes mem[wr_ptr], wr_ptr = wr_ptr+1 mod DEPTH, count+1. When count would reach DEPTH, go to FULL.
  - FULL: data_valid sets overflow and the sample is dropped. When count < DEPTH (after a pop) and enable, return to CAPTURE.
  - Any state except IDLE: enable low goes to IDLE. Stored data stays readable.
- sink_ready = 1 in SKIP or CAPTURE. Upstream uses it for gating only; samples are never back-pressured.
- Read side:
  - rd_req is accepted only when fifo_vacio is 0; otherwise it is ignored and no rd_valid is produced.
  - Low half (half = 0): the whole word mem[rd_ptr] is latched into a 64-bit holding register. Next cycle: rd_data = bits[31:0], rd_valid = 1, half becomes 1.
  - High half (half = 1): next cycle rd_data = holding[63:32], rd_valid = 1, half becomes 0. Pop: rd_ptr+1 mod DEPTH, count-1.
  - Read latency is 1 cycle for both halves. Back-to-back rd_req every cycle is supported.
  - rd_data holds its last value when rd_valid is 0.
- Simultaneous write and pop in the same cycle: count unchanged and both pointers advance. A write in FULL together with a pop is still dropped, because the state is evaluated before the pop.
- Pointer wrap-around is natural modulo DEPTH. Full/empty come from count, never from a pointer compare.
- Reading while capturing is allowed. A read never addresses the word being written, because count > 0 guarantees rd_ptr != wr_ptr unless full, and writes are blocked when full.
- fifo_lleno, fifo_vacio and count are registered and reflect the state after the current cycle's updates.

Decomposition:
- Shared package holds: state encoding (IDLE, SKIP, CAPTURE, FULL); default DEPTH/ADDR_W; the 64-bit sample width constant used by all processing blocks.
- One sub-module, capture_ram:
  - simple dual-port inferred RAM, DEPTH x 64.
  - one write port and one read port, registered read with latency 1.
  - no reset on the array.

Test Plan:
1. Reset then enable=1, SKIP=0, 4 valid samples 1,2,3,4, then 8 rd_req -> rd_data sequence 1,0,2,0,3,0,4,0. count goes 4 -> 0, fifo_vacio = 1 at end.
2. SKIP=3, enable=1, samples 10..15 -> only 13,14,15 stored. count = 3, first low half read = 13.
3. DEPTH=8: 10 valid samples -> fifo_lleno = 1 after the 8th, overflow = 1 after the 9th. The first 8 samples read back intact; the 9th and 10th are absent.
4. From FULL (DEPTH=8): one full pop, i.e. two rd_req, then one sample 0xABCD -> state back to CAPTURE. count returns to 8. That sample is read last after wrap-around (wr_ptr wrapped to 0).
5. Write data_valid and high-half rd_req in the same cycle with count = 5 -> count stays 5 and both pointers advance.
6. Sample -1 (all ones), then clear in the same cycle as an rd_req -> no rd_valid, count = 0, overflow = 0, state IDLE. Re-arm, then sample 0x8000_0000_0000_0001 reads back as 0x00000001 then 0x80000000.

Source files
------------

// File: rtl/stream_capture_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_capture_buffer_pkg
// Description : Shared definitions for the stream capture buffer: FSM state
//               encoding, default buffer geometry and the processing-stream
//               sample width shared by all processing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_capture_buffer_pkg;

    // Width of one sample on the processing stream
    localparam int unsigned SAMPLE_W       = 64;

    // Default buffer geometry
    localparam int unsigned DEFAULT_DEPTH  = 2048;
    localparam int unsigned DEFAULT_ADDR_W = 11;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FULL    = 2'd3
    } cap_state_t;

endpackage : stream_capture_buffer_pkg
`default_nettype wire

// File: rtl/stream_capture_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : capture_ram
// Description : Simple dual-port inferred RAM, DEPTH x WIDTH. One write port,
//               one read port with a registered output (latency 1). The array
//               itself carries no reset; the read register only changes when
//               i_rd_en is high, so it holds the last word read.
// Ports       : clock      - system clock
//               i_wr_en    - write strobe
//               i_wr_addr  - write address
//               i_wr_data  - write data
//               i_rd_en    - read strobe
//               i_rd_addr  - read address
//               o_rd_data  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module capture_ram #(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned WIDTH  = 64
) (
    input  logic              clock,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_q;

endmodule : capture_ram
`default_nettype wire

// File: rtl/stream_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_capture_buffer
// Description : Sink for the 64-bit processing stream. Optionally discards
//               SKIP samples after arming, then stores samples into a DEPTH
//               word buffer. The host drains each sample as two 32-bit halves
//               (low first) over a request/valid port with 1-cycle latency.
// Ports       : clock, reset_n   - clock, asynchronous active-low reset
//               enable           - arm capture (low -> IDLE, data kept)
//               clear            - synchronous flush of buffer and flags
//               data_valid, data - input sample stream
//               sink_ready       - storing or skipping samples
//               rd_req           - read one 32-bit half
//               rd_data/rd_valid - read response
//               count            - stored samples
//               fifo_lleno       - buffer full
//               fifo_vacio       - buffer empty
//               overflow         - sticky, sample dropped while full
// Revision    : 1.0 - initial release
// ============================================================================
module stream_capture_buffer
    import stream_capture_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned SKIP   = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       data_valid,
    input  logic signed [SAMPLE_W-1:0] data,
    output logic                       sink_ready,
    input  logic                       rd_req,
    output logic [31:0]                rd_data,
    output logic                       rd_valid,
    output logic [ADDR_W:0]            count,
    output logic                       fifo_lleno,
    output logic                       fifo_vacio,
    output logic                       overflow
);

    localparam logic [ADDR_W:0] c_depth_cnt = (ADDR_W+1)'(DEPTH);

    cap_state_t            r_state;
    cap_state_t            w_state_nxt;
    cap_state_t            w_arm_target;

    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [ADDR_W:0]       r_count;
    logic [ADDR_W:0]       w_count_nxt;
    logic [31:0]           r_skip_cnt;
    logic                  r_half;      // 0: next read is low half
    logic                  r_out_hi;    // half presented on rd_data
    logic                  r_loaded;    // RAM read register holds a real word
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_lleno;
    logic                  r_vacio;

    logic                  w_wr;
    logic                  w_rd_acc;
    logic                  w_rd_lo;
    logic                  w_pop;
    logic                  w_ovf_evt;
    logic [SAMPLE_W-1:0]   w_ram_q;

    // ------------------------------------------------------------------------
    // Datapath strobes
    // ------------------------------------------------------------------------
    assign w_wr      = (r_state == ST_CAPTURE) && enable && data_valid && !clear;
    assign w_ovf_evt = (r_state == ST_FULL) && enable && data_valid && !clear;
    assign w_rd_acc  = rd_req && !r_vacio && !clear;
    assign w_rd_lo   = w_rd_acc && !r_half;
    assign w_pop     = w_rd_acc && r_half;

    // Re-arming onto a buffer that was left full must not overwrite it
    assign w_arm_target = r_lleno ? ST_FULL : ST_CAPTURE;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_wr) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear || !enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = (SKIP == 0) ? w_arm_target : ST_SKIP;
                end
                ST_SKIP: begin
                    // The sample completing the skip is itself discarded
                    if (data_valid && (r_skip_cnt + 32'd1 == SKIP)) begin
                        w_state_nxt = w_arm_target;
                    end
                end
                ST_CAPTURE: begin
                    if (w_wr && (w_count_nxt == c_depth_cnt)) begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!r_lleno) begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Skip counter is held at zero outside SKIP, so it starts fresh on entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_skip_cnt <= '0;
        end else if (clear || (r_state != ST_SKIP)) begin
            r_skip_cnt <= '0;
        end else if (enable && data_valid) begin
            r_skip_cnt <= r_skip_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy, flags and read handshake
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lleno    <= 1'b0;
            r_vacio    <= 1'b1;
            r_overflow <= 1'b0;
            r_half     <= 1'b0;
            r_out_hi   <= 1'b0;
            r_loaded   <= 1'b0;
            r_rd_valid <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lleno    <= 1'b0;
            r_vacio    <= 1'b1;
            r_overflow <= 1'b0;
            r_half     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_lleno <= (w_count_nxt == c_depth_cnt);
            r_vacio <= (w_count_nxt == '0);
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_half   <= ~r_half;
                r_out_hi <= r_half;
                r_loaded <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sample storage. The RAM read register doubles as the 64-bit holding
    // register: it is loaded on a low-half request and left untouched on the
    // high-half request, so both halves come from the same word.
    // ------------------------------------------------------------------------
    capture_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (SAMPLE_W)
    ) u_capture_ram (
        .clock     (clock),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data),
        .i_rd_en   (w_rd_lo),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    // Output holds the last presented half until the next accepted read
    assign rd_data    = !r_loaded ? 32'd0 :
                        (r_out_hi ? w_ram_q[63:32] : w_ram_q[31:0]);
    assign rd_valid   = r_rd_valid;
    assign sink_ready = (r_state == ST_SKIP) || (r_state == ST_CAPTURE);
    assign count      = r_count;
    assign fifo_lleno = r_lleno;
    assign fifo_vacio = r_vacio;
    assign overflow   = r_overflow;

endmodule : stream_capture_buffer
`default_nettype wire

// File: tb/tb_stream_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_capture_buffer
// Description : Scoreboard testbench. Instance A: DEPTH=8, SKIP=0. Instance
//               B: DEPTH=16, SKIP=3. Expected read halves are queued when a
//               request is issued; monitors pop and compare on rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_capture_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A
    logic               a_en, a_clr, a_dv, a_rq;
    logic signed [63:0] a_d;
    logic               a_sr, a_rv, a_ll, a_va, a_ov;
    logic [31:0]        a_rd;
    logic [3:0]         a_cnt;

    // Instance B
    logic               b_en, b_clr, b_dv, b_rq;
    logic signed [63:0] b_d;
    logic               b_sr, b_rv, b_ll, b_va, b_ov;
    logic [31:0]        b_rd;
    logic [4:0]         b_cnt;

    stream_capture_buffer #(.DEPTH(8), .ADDR_W(3), .SKIP(0)) u_dut_a (
        .clock(clk), .reset_n(rst_n), .enable(a_en), .clear(a_clr),
        .data_valid(a_dv), .data(a_d), .sink_ready(a_sr), .rd_req(a_rq),
        .rd_data(a_rd), .rd_valid(a_rv), .count(a_cnt),
        .fifo_lleno(a_ll), .fifo_vacio(a_va), .overflow(a_ov)
    );

    stream_capture_buffer #(.DEPTH(16), .ADDR_W(4), .SKIP(3)) u_dut_b (
        .clock(clk), .reset_n(rst_n), .enable(b_en), .clear(b_clr),
        .data_valid(b_dv), .data(b_d), .sink_ready(b_sr), .rd_req(b_rq),
        .rd_data(b_rd), .rd_valid(b_rv), .count(b_cnt),
        .fifo_lleno(b_ll), .fifo_vacio(b_va), .overflow(b_ov)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] exp_a, exp_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (rst_n && a_rv) begin
            if (q_a.size() == 0) begin
                n_total++;
                $display("FAIL a_unexpected_rd_valid: got data %0h expected no response", a_rd);
            end else begin
                exp_a = q_a.pop_front();
                check("a_rd_data", {32'd0, a_rd}, {32'd0, exp_a});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_rv) begin
            if (q_b.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected_rd_valid: got data %0h expected no response", b_rd);
            end else begin
                exp_b = q_b.pop_front();
                check("b_rd_data", {32'd0, b_rd}, {32'd0, exp_b});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [63:0] v);
        a_dv = 1'b1; a_d = v;
        tick();
        a_dv = 1'b0;
    endtask

    task automatic a_read(input logic [31:0] e);
        q_a.push_back(e);
        a_rq = 1'b1;
        tick();
        a_rq = 1'b0;
    endtask

    task automatic a_read_word(input logic [63:0] w);
        a_read(w[31:0]);
        a_read(w[63:32]);
    endtask

    task automatic b_write(input logic [63:0] v);
        b_dv = 1'b1; b_d = v;
        tick();
        b_dv = 1'b0;
    endtask

    task automatic b_read(input logic [31:0] e);
        q_b.push_back(e);
        b_rq = 1'b1;
        tick();
        b_rq = 1'b0;
    endtask

    logic [63:0] s_val [10];

    initial begin
        rst_n = 1'b0;
        a_en = 0; a_clr = 0; a_dv = 0; a_rq = 0; a_d = '0;
        b_en = 0; b_clr = 0; b_dv = 0; b_rq = 0; b_d = '0;
        repeat (3) tick();

        // Reset state
        check("rst_count",     64'(a_cnt), 64'd0);
        check("rst_vacio",     64'(a_va),  64'd1);
        check("rst_lleno",     64'(a_ll),  64'd0);
        check("rst_overflow",  64'(a_ov),  64'd0);
        check("rst_sink_rdy",  64'(a_sr),  64'd0);
        check("rst_rd_valid",  64'(a_rv),  64'd0);
        check("rst_rd_data",   64'(a_rd),  64'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic capture and half-word readout
        a_en = 1'b1;
        tick();
        check("t1_sink_rdy", 64'(a_sr), 64'd1);
        for (int i = 1; i <= 4; i++) a_write(64'(i));
        check("t1_count4", 64'(a_cnt), 64'd4);
        for (int i = 1; i <= 4; i++) a_read_word(64'(i));
        check("t1_count0", 64'(a_cnt), 64'd0);
        check("t1_vacio",  64'(a_va),  64'd1);

        // Read while empty is ignored
        a_rq = 1'b1;
        tick();
        a_rq = 1'b0;
        check("empty_read_no_valid", 64'(a_rv), 64'd0);

        // 5: simultaneous write and high-half pop
        for (int i = 0; i < 5; i++) a_write({32'hA0 + 32'(i), 32'h100 + 32'(i)});
        check("t5_count5", 64'(a_cnt), 64'd5);
        a_read(32'h100);
        q_a.push_back(32'hA0);
        a_rq = 1'b1; a_dv = 1'b1; a_d = {32'hA5, 32'h105};
        tick();
        a_rq = 1'b0; a_dv = 1'b0;
        check("t5_count_same", 64'(a_cnt), 64'd5);
        for (int i = 1; i <= 5; i++) a_read_word({32'hA0 + 32'(i), 32'h100 + 32'(i)});
        check("t5_count0", 64'(a_cnt), 64'd0);

        // 3: fill to DEPTH and overflow
        for (int i = 0; i < 10; i++) s_val[i] = {32'hC000_0000 | 32'(i), 32'h1000 + 32'(i)};
        for (int i = 0; i < 8; i++) a_write(s_val[i]);
        check("t3_lleno",     64'(a_ll),  64'd1);
        check("t3_count8",    64'(a_cnt), 64'd8);
        check("t3_no_ovf_yet", 64'(a_ov), 64'd0);
        a_write(s_val[8]);
        check("t3_overflow",  64'(a_ov),  64'd1);
        a_write(s_val[9]);
        check("t3_count_held", 64'(a_cnt), 64'd8);
        check("t3_full_not_ready", 64'(a_sr), 64'd0);

        // 4: one pop out of FULL, then a new sample lands after wrap-around
        a_read_word(s_val[0]);
        check("t4_count7", 64'(a_cnt), 64'd7);
        tick();
        tick();
        check("t4_back_capture", 64'(a_sr), 64'd1);
        a_write(64'hABCD);
        check("t4_count8", 64'(a_cnt), 64'd8);
        check("t4_lleno",  64'(a_ll),  64'd1);
        for (int i = 1; i < 8; i++) a_read_word(s_val[i]);
        a_read_word(64'hABCD);
        check("t4_count0", 64'(a_cnt), 64'd0);
        check("t4_ovf_sticky", 64'(a_ov), 64'd1);

        // 6: clear with concurrent rd_req
        a_write(64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_count1", 64'(a_cnt), 64'd1);
        a_clr = 1'b1; a_rq = 1'b1;
        tick();
        a_clr = 1'b0; a_rq = 1'b0;
        check("t6_no_valid", 64'(a_rv),  64'd0);
        check("t6_count0",   64'(a_cnt), 64'd0);
        check("t6_ovf_clr",  64'(a_ov),  64'd0);
        check("t6_idle",     64'(a_sr),  64'd0);
        check("t6_vacio",    64'(a_va),  64'd1);
        tick();
        check("t6_rearmed", 64'(a_sr), 64'd1);
        a_write(64'h8000_0000_0000_0001);
        a_read(32'h0000_0001);
        a_read(32'h8000_0000);
        tick();
        tick();
        check("t6_rd_data_hold", 64'(a_rd), 64'h8000_0000);
        check("t6_end_vacio",    64'(a_va), 64'd1);

        // 2: SKIP=3 on instance B
        b_en = 1'b1;
        tick();
        check("t2_skip_ready", 64'(b_sr), 64'd1);
        for (int i = 10; i <= 15; i++) b_write(64'(i));
        check("t2_count3", 64'(b_cnt), 64'd3);
        for (int i = 13; i <= 15; i++) begin
            b_read(32'(i));
            b_read(32'd0);
        end
        check("t2_vacio", 64'(b_va), 64'd1);

        repeat (3) tick();
        check("a_scoreboard_drained", 64'(q_a.size()), 64'd0);
        check("b_scoreboard_drained", 64'(q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_stream_capture_buffer
`default_nettype wire
